// File: rtl/register_file_if.sv
// Bus-side signal bundle for register_file: one write port, one clear port
// and two read ports. The master drives addresses and data; the slave
// (the register file) returns read data.
interface register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] BUS_MUX_OUT;
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_b;

    modport master (
        output wr_en, wr_addr, BUS_MUX_OUT, clr_en, clr_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  wr_en, wr_addr, BUS_MUX_OUT, clr_en, clr_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b
    );
endinterface

// File: rtl/register_file.sv
// Parametrised register array: one bus-fed write port, one synchronous
// single-register clear, two independent combinational read ports, optional
// hardwired-zero R0 and optional same-cycle write/clear forwarding.
module register_file #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter bit                    R0_ZERO     = 1'b1,
    parameter bit                    BYPASS      = 1'b1
) (
    input logic            clock,
    input logic            clear,
    register_file_if.slave bus
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    // Low from reset until the first edge after release, so the edge that
    // coincides with deassertion never updates state.
    logic                  r_active;
    logic                  w_wr_valid;
    logic                  w_clr_valid;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    function automatic logic in_range(logic [ADDR_WIDTH-1:0] addr);
        return 32'(addr) < NUM_REGS;
    endfunction

    assign w_wr_valid  = r_active && bus.wr_en && in_range(bus.wr_addr) &&
                         !(R0_ZERO && bus.wr_addr == '0);
    assign w_clr_valid = r_active && bus.clr_en && in_range(bus.clr_addr);

    // Tracks whether at least one edge has passed since reset release.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Register array update; the clear is scheduled last so it wins on a
    // same-address collision with a write.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= (R0_ZERO && i == 0) ? '0 : RESET_VALUE;
            end
        end else begin
            if (w_wr_valid) begin
                r_regs[bus.wr_addr] <= bus.BUS_MUX_OUT;
            end
            if (w_clr_valid) begin
                r_regs[bus.clr_addr] <= '0;
            end
        end
    end

    // Read port A: hardwired/out-of-range zero, then forwarding, then storage.
    always_comb begin
        w_rd_a = '0;
        if (!in_range(bus.rd_addr_a) || (R0_ZERO && bus.rd_addr_a == '0)) begin
            w_rd_a = '0;
        end else if (BYPASS && w_clr_valid && bus.clr_addr == bus.rd_addr_a) begin
            w_rd_a = '0;
        end else if (BYPASS && w_wr_valid && bus.wr_addr == bus.rd_addr_a) begin
            w_rd_a = bus.BUS_MUX_OUT;
        end else begin
            w_rd_a = r_regs[bus.rd_addr_a];
        end
    end

    // Read port B: identical selection, fully independent of port A.
    always_comb begin
        w_rd_b = '0;
        if (!in_range(bus.rd_addr_b) || (R0_ZERO && bus.rd_addr_b == '0)) begin
            w_rd_b = '0;
        end else if (BYPASS && w_clr_valid && bus.clr_addr == bus.rd_addr_b) begin
            w_rd_b = '0;
        end else if (BYPASS && w_wr_valid && bus.wr_addr == bus.rd_addr_b) begin
            w_rd_b = bus.BUS_MUX_OUT;
        end else begin
            w_rd_b = r_regs[bus.rd_addr_b];
        end
    end

    assign bus.rd_data_a = w_rd_a;
    assign bus.rd_data_b = w_rd_b;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: two instances driven by identical stimulus.
// Instance 0: 16 regs, reset DEADBEEF, hardwired R0, bypass on.
// Instance 1: 12 regs, reset 0BADF00D, ordinary R0, bypass off.
module tb_register_file;

    localparam logic [31:0] Rv0 = 32'hDEADBEEF;
    localparam logic [31:0] Rv1 = 32'h0BADF00D;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wdata = '0;
    logic        clr_en = 1'b0;
    logic [3:0]  clr_addr = '0;
    logic [3:0]  rd_a = '0;
    logic [3:0]  rd_b = '0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

    assign bus0.wr_en = wr_en;       assign bus1.wr_en = wr_en;
    assign bus0.wr_addr = wr_addr;   assign bus1.wr_addr = wr_addr;
    assign bus0.BUS_MUX_OUT = wdata; assign bus1.BUS_MUX_OUT = wdata;
    assign bus0.clr_en = clr_en;     assign bus1.clr_en = clr_en;
    assign bus0.clr_addr = clr_addr; assign bus1.clr_addr = clr_addr;
    assign bus0.rd_addr_a = rd_a;    assign bus1.rd_addr_a = rd_a;
    assign bus0.rd_addr_b = rd_b;    assign bus1.rd_addr_b = rd_b;

    register_file #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4), .RESET_VALUE(Rv0),
                    .R0_ZERO(1'b1), .BYPASS(1'b1))
        dut0 (.clock(clock), .clear(clear), .bus(bus0));

    register_file #(.DATA_WIDTH(32), .NUM_REGS(12), .ADDR_WIDTH(4), .RESET_VALUE(Rv1),
                    .R0_ZERO(1'b0), .BYPASS(1'b0))
        dut1 (.clock(clock), .clear(clear), .bus(bus1));

    // Reference model: contents per instance plus "an edge has passed since reset".
    logic [31:0] m_mem [2][16];
    logic        m_active;

    function automatic int nregs(int k);
        return (k == 0) ? 16 : 12;
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_active <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_mem[0][i] <= (i == 0) ? 32'h0 : Rv0;
                m_mem[1][i] <= Rv1;
            end
        end else begin
            m_active <= 1'b1;
            if (m_active) begin
                for (int k = 0; k < 2; k++) begin
                    if (wr_en && int'(wr_addr) < nregs(k) && !(k == 0 && wr_addr == 0))
                        m_mem[k][wr_addr] <= wdata;
                    if (clr_en && int'(clr_addr) < nregs(k))
                        m_mem[k][clr_addr] <= 32'h0;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(int k, logic [3:0] a);
        if (int'(a) >= nregs(k)) return 32'h0;
        if (k == 0 && a == 0) return 32'h0;
        if (k == 0 && m_active && clear) begin
            if (clr_en && clr_addr == a) return 32'h0;
            if (wr_en && wr_addr == a) return wdata;
        end
        return m_mem[k][a];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(string name);
        check({name, "_a0"}, bus0.rd_data_a, exp_rd(0, rd_a));
        check({name, "_b0"}, bus0.rd_data_b, exp_rd(0, rd_b));
        check({name, "_a1"}, bus1.rd_data_a, exp_rd(1, rd_a));
        check({name, "_b1"}, bus1.rd_data_b, exp_rd(1, rd_b));
    endtask

    task automatic drive(logic we, logic [3:0] wa, logic [31:0] wd,
                         logic ce, logic [3:0] ca, logic [3:0] ra, logic [3:0] rb);
        wr_en = we; wr_addr = wa; wdata = wd; clr_en = ce; clr_addr = ca;
        rd_a = ra; rd_b = rb;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        ce;
        logic [3:0]  ca;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] ea0, eb0, ea1, eb1;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Expected values are the pre-edge reads; each row's write/clear lands at its edge.
        vecs[0]  = '{0, 0, 0, 0, 0, 5, 0, Rv0, 0, Rv1, Rv1};
        vecs[1]  = '{1, 3, 32'h12345678, 0, 0, 3, 3, 32'h12345678, 32'h12345678, Rv1, Rv1};
        vecs[2]  = '{0, 0, 0, 0, 0, 3, 3, 32'h12345678, 32'h12345678,
                     32'h12345678, 32'h12345678};
        vecs[3]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 3, 0, 32'h12345678, Rv1, 32'h12345678};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 13, 0, Rv0, 32'hFFFFFFFF, 0};
        vecs[5]  = '{1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, Rv1, Rv1};
        vecs[6]  = '{0, 0, 0, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5,
                     32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[7]  = '{1, 2, 32'h55, 1, 2, 2, 4, 0, Rv0, Rv1, Rv1};
        vecs[8]  = '{1, 4, 32'h66, 1, 2, 2, 4, 0, 32'h66, 0, Rv1};
        vecs[9]  = '{0, 0, 0, 0, 0, 2, 4, 0, 32'h66, 0, 32'h66};
        vecs[10] = '{1, 13, 32'h99, 0, 0, 13, 12, 32'h99, Rv0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 13, 11, 32'h99, Rv0, 0, Rv1};
        vecs[12] = '{0, 0, 0, 1, 15, 15, 13, 0, 32'h99, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 15, 1, 0, Rv0, 0, Rv1};

        // Reset state, checked while reset is still held.
        drive(0, 0, 0, 0, 0, 5, 0);
        repeat (2) @(negedge clock);
        #1;
        check("rst_a0", bus0.rd_data_a, Rv0);
        check("rst_b0", bus0.rd_data_b, 32'h0);
        check("rst_a1", bus1.rd_data_a, Rv1);
        check("rst_b1", bus1.rd_data_b, Rv1);
        clear = 1'b1;
        repeat (2) @(posedge clock);

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ce, vecs[i].ca,
                  vecs[i].ra, vecs[i].rb);
            #1;
            check($sformatf("vec%0d_a0", i), bus0.rd_data_a, vecs[i].ea0);
            check($sformatf("vec%0d_b0", i), bus0.rd_data_b, vecs[i].eb0);
            check($sformatf("vec%0d_a1", i), bus1.rd_data_a, vecs[i].ea1);
            check($sformatf("vec%0d_b1", i), bus1.rd_data_b, vecs[i].eb1);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) rd_b = wr_addr;
            if ($urandom_range(0, 5) == 0) clr_addr = wr_addr;
            #1;
            check_model($sformatf("rnd%0d", i));
        end

        // Fill registers 1..15 with nonzero values, then assert reset mid-cycle.
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            drive(1, 4'(i), 32'h10000000 | i, 0, 0, 0, 0);
        end
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 5, 9);
        #1;
        check("pre_rst_a0", bus0.rd_data_a, 32'h10000005);
        check("pre_rst_b0", bus0.rd_data_b, 32'h10000009);
        check("pre_rst_a1", bus1.rd_data_a, 32'h10000005);
        check("pre_rst_b1", bus1.rd_data_b, 32'h10000009);
        #1 clear = 1'b0;
        #1;
        check("async_a0", bus0.rd_data_a, Rv0);
        check("async_b0", bus0.rd_data_b, Rv0);
        check("async_a1", bus1.rd_data_a, Rv1);
        check("async_b1", bus1.rd_data_b, Rv1);
        for (int a = 0; a < 16; a++) begin
            @(negedge clock);
            rd_a = 4'(a);
            rd_b = 4'(15 - a);
            #1;
            check_model($sformatf("rstsweep%0d", a));
        end

        // Release reset on an edge while a write is presented: write must be dropped.
        @(negedge clock);
        drive(1, 5, 32'h77, 0, 0, 5, 6);
        #1;
        check("held_a0", bus0.rd_data_a, Rv0);
        check("held_a1", bus1.rd_data_a, Rv1);
        @(posedge clock);
        clear = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        #1;
        check("rel_a0", bus0.rd_data_a, Rv0);
        check("rel_a1", bus1.rd_data_a, Rv1);
        @(negedge clock);
        drive(1, 6, 32'h88, 0, 0, 5, 6);
        @(negedge clock);
        wr_en = 1'b0;
        #1;
        check("resume_a0", bus0.rd_data_a, Rv0);
        check("resume_b0", bus0.rd_data_b, 32'h88);
        check("resume_a1", bus1.rd_data_a, Rv1);
        check("resume_b1", bus1.rd_data_b, 32'h88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
